// File: rtl/rgb_sdec_pkg.sv
// rgb_sdec_pkg: FSM states and 96 MHz default timing shared by the RGB line decoder
package rgb_sdec_pkg;
  typedef enum logic [1:0] {S_WAIT = 2'd0, S_LOW = 2'd1, S_HIGH = 2'd2} state_t;
  localparam int DEF_BIT_THRESH = 58;
  localparam int DEF_MIN_HIGH = 8;
  localparam int DEF_MAX_HIGH = 200;
  localparam int DEF_RST_CLKS = 4800;
  localparam int DEF_STROBE_LEN = 2;
  localparam int DEF_COUNTER_MAX = 7800;
endpackage

// File: rtl/rgb_sync2.sv
// rgb_sync2: two-flop synchronizer for the asynchronous serial line
module rgb_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/rgb_sdec.sv
// rgb_sdec: WS2812-style pulse-width decoder; RGB_SDEC_BITCNT_EN adds out_bit_count
module rgb_sdec
  import rgb_sdec_pkg::*;
#(
  parameter int BIT_THRESH = DEF_BIT_THRESH,
  parameter int MIN_HIGH = DEF_MIN_HIGH,
  parameter int MAX_HIGH = DEF_MAX_HIGH,
  parameter int RST_CLKS = DEF_RST_CLKS,
  parameter int STROBE_LEN = DEF_STROBE_LEN,
  parameter int COUNTER_MAX = DEF_COUNTER_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic in_sig,
  output logic out_strobe,
  output logic out_sbit_value,
  output logic out_stream_reset,
  output logic out_err
`ifdef RGB_SDEC_BITCNT_EN
  ,
  output logic [15:0] out_bit_count
`endif
);
  localparam int CW = $clog2(COUNTER_MAX + 1);
  localparam logic [CW-1:0] C_MAX = CW'(COUNTER_MAX);
  localparam logic [CW-1:0] C_THR = CW'(BIT_THRESH);
  localparam logic [CW-1:0] C_MIN = CW'(MIN_HIGH);
  localparam logic [CW-1:0] C_MAXH = CW'(MAX_HIGH);
  localparam logic [CW-1:0] C_RST = CW'(RST_CLKS);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [7:0] S_LEN1 = 8'(STROBE_LEN - 1);
  state_t st;
  logic [CW-1:0] cnt, cnt_inc;
  logic [7:0] scnt;
  logic sig_s, sig_d, rst_sent, rise, fall, over, glitch, ev_bit, ev_rst, ev;
  rgb_sync2 u_sync (.clk(clk), .rst(rst), .d(in_sig), .q(sig_s));
  // cnt always holds the number of clks of the current level completed before this clk
  always_comb begin
    rise = sig_s & ~sig_d;
    fall = ~sig_s & sig_d;
    cnt_inc = (cnt == C_MAX) ? cnt : cnt + C_ONE;
    over = (st == S_HIGH) && (cnt > C_MAXH);
    glitch = (st == S_HIGH) && !over && fall && (cnt < C_MIN);
    ev_bit = (st == S_HIGH) && !over && fall && (cnt >= C_MIN);
    ev_rst = (st == S_LOW) && !rst_sent && (cnt >= C_RST);
    ev = ev_bit | ev_rst;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= S_WAIT;
      cnt <= '0;
      sig_d <= 1'b0;
      rst_sent <= 1'b0;
    end else begin
      sig_d <= sig_s;
      case (st)
        S_WAIT: begin
          cnt <= sig_s ? '0 : cnt_inc;
          if (!sig_s && cnt_inc >= C_RST) begin
            st <= S_LOW;
            rst_sent <= 1'b1;
          end
        end
        S_LOW: begin
          cnt <= rise ? C_ONE : cnt_inc;
          st <= rise ? S_HIGH : S_LOW;
          if (ev_rst) rst_sent <= 1'b1;
        end
        S_HIGH: begin
          if (over) begin
            st <= S_WAIT;
            cnt <= '0;
          end else if (fall) begin
            st <= S_LOW;
            cnt <= C_ONE;
            rst_sent <= 1'b0;
          end else cnt <= cnt_inc;
        end
        default: st <= S_WAIT;
      endcase
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {out_strobe, out_sbit_value, out_stream_reset, out_err} <= 4'b0000;
      scnt <= '0;
    end else begin
      if (ev) begin
        out_strobe <= 1'b1;
        out_sbit_value <= ev_bit && (cnt >= C_THR);
        out_stream_reset <= ev_rst;
        scnt <= S_LEN1;
      end else if (scnt != 8'd0) scnt <= scnt - 8'd1;
      else {out_strobe, out_sbit_value, out_stream_reset} <= 3'b000;
      if (over || glitch || (ev && out_strobe)) out_err <= 1'b1;
    end
`ifdef RGB_SDEC_BITCNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) out_bit_count <= '0;
    else if (ev_rst) out_bit_count <= '0;
    else if (ev_bit && out_bit_count != 16'hFFFF) out_bit_count <= out_bit_count + 16'd1;
`endif
endmodule

// File: tb/tb_rgb_sdec.sv
// tb_rgb_sdec: directed pulse-width vectors with hand-computed decoded events
module tb_rgb_sdec;
  logic clk = 1'b0, rst = 1'b0, in_sig = 1'b0;
  logic out_strobe, out_sbit_value, out_stream_reset, out_err;
`ifdef RGB_SDEC_BITCNT_EN
  logic [15:0] out_bit_count;
`endif
  int n_run = 0, n_fail = 0, w = 0;
  logic [1:0] evq[$];
  int widq[$];
  always #5 clk = ~clk;
  rgb_sdec dut (
    .clk(clk),
    .rst(rst),
    .in_sig(in_sig),
    .out_strobe(out_strobe),
    .out_sbit_value(out_sbit_value),
    .out_stream_reset(out_stream_reset),
    .out_err(out_err)
`ifdef RGB_SDEC_BITCNT_EN
    ,
    .out_bit_count(out_bit_count)
`endif
  );
  // each strobe is logged as {value, reset} on its first clk, its width when it drops
  always @(negedge clk)
    if (out_strobe) begin
      if (w == 0) evq.push_back({out_sbit_value, out_stream_reset});
      w++;
    end else if (w != 0) begin
      widq.push_back(w);
      w = 0;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic line(input logic v, input int n);
    in_sig = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input int h, input int l);
    line(1'b1, h);
    line(1'b0, l);
  endtask
  task automatic send_bit(input logic b);
    send(b ? 77 : 38, b ? 13 : 52);
  endtask
  task automatic expect_ev(input string tag, input int n, input logic [31:0] vals, input logic [31:0] rsts);
    logic [1:0] e;
    chk({tag, " count"}, evq.size(), n);
    for (int i = 0; i < n && evq.size() > 0; i++) begin
      e = evq.pop_front();
      chk($sformatf("%s ev%0d", tag, i), {30'd0, e}, {30'd0, vals[i], rsts[i]});
    end
    while (widq.size() > 0) chk({tag, " width"}, widq.pop_front(), 2);
    evq.delete();
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset outs", {out_strobe, out_sbit_value, out_stream_reset, out_err}, 4'b0000);
    rst = 1'b1;
    line(1'b0, 4810);
    expect_ev("initial low", 0, 0, 0);
    send_bit(1'b0);
    expect_ev("first bit0", 1, 0, 0);
    send(77, 13);
    send(57, 33);
    send(58, 32);
    expect_ev("thresh", 3, 32'b101, 0);
    send(8, 40);
    send(200, 40);
    expect_ev("min max", 2, 32'b10, 0);
    send(38, 4799);
    send(77, 13);
    expect_ev("low 4799", 2, 32'b10, 0);
    send(38, 4800);
    send(77, 13);
    expect_ev("low 4800", 3, 32'b100, 32'b010);
    line(1'b0, 4800);
    expect_ev("pre reset", 1, 0, 1);
    for (int i = 0; i < 24; i++) send_bit(i % 2 == 0);
`ifdef RGB_SDEC_BITCNT_EN
    chk("bitcnt 24", {16'd0, out_bit_count}, 24);
`endif
    line(1'b0, 4810);
    expect_ev("24 bits", 25, 32'h0055_5555, 32'h0100_0000);
`ifdef RGB_SDEC_BITCNT_EN
    chk("bitcnt cleared", {16'd0, out_bit_count}, 0);
`endif
    chk("err clean", {31'd0, out_err}, 0);
    send(5, 40);
    chk("err glitch", {31'd0, out_err}, 1);
    expect_ev("glitch", 0, 0, 0);
    send_bit(1'b1);
    send_bit(1'b0);
    expect_ev("after glitch", 2, 32'b01, 0);
    send(201, 40);
    send_bit(1'b1);
    expect_ev("high 201", 0, 0, 0);
    line(1'b0, 4810);
    send_bit(1'b1);
    expect_ev("resync 201", 1, 1, 0);
    send(300, 40);
    send_bit(1'b1);
    send_bit(1'b0);
    expect_ev("stuck high", 0, 0, 0);
    line(1'b0, 4810);
    send_bit(1'b0);
    send_bit(1'b1);
    expect_ev("resync 300", 2, 32'b10, 0);
    line(1'b1, 30);
    rst = 1'b0;
    #1;
    chk("mid reset outs", {out_strobe, out_sbit_value, out_stream_reset, out_err}, 4'b0000);
`ifdef RGB_SDEC_BITCNT_EN
    chk("mid reset bitcnt", {16'd0, out_bit_count}, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    line(1'b1, 300);
    line(1'b0, 100);
    send_bit(1'b1);
    expect_ev("post reset", 0, 0, 0);
    line(1'b0, 4810);
    send_bit(1'b0);
    expect_ev("post resync", 1, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
